// File: rtl/dmem_port_arbiter.sv
// Arbitrates the single-port data memory between the core memory stage and the debug port.
// Optional perf counters (perf_conflicts, perf_dbg_stall) are built when DMEM_ARB_PERF_EN is defined.
module dmem_port_arbiter #(
    parameter int ADDR_W   = 10,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 8
) (
    input  logic                clk,
    input  logic                rst_BF,
    input  logic                core_req,
    input  logic                core_we,
    input  logic [ADDR_W-1:0]   core_addr,
    input  logic [DATA_W-1:0]   core_wdata,
    input  logic [DATA_W/8-1:0] core_be,
    output logic                core_gnt,
    output logic                core_rvalid,
    output logic [DATA_W-1:0]   core_rdata,
    input  logic                dbg_req,
    input  logic                dbg_we,
    input  logic                dbg_lock,
    input  logic [ADDR_W-1:0]   dbg_addr,
    input  logic [DATA_W-1:0]   dbg_wdata,
    output logic                dbg_gnt,
    output logic                dbg_rvalid,
    output logic [DATA_W-1:0]   dbg_rdata,
    output logic                dbg_locked,
    output logic                mem_en,
    output logic                mem_we,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata
`ifdef DMEM_ARB_PERF_EN
    ,
    output logic [31:0]         perf_conflicts,
    output logic [31:0]         perf_dbg_stall
`endif
);

    localparam logic [7:0] MAX_W = 8'(MAX_WAIT);

    typedef enum logic [1:0] {
        ARB_CORE,
        ARB_STARVE,
        ARB_LOCK
    } arb_state_e;

    arb_state_e        state_q;
    logic [7:0]        wait_cnt_q, wait_cnt_d;
    logic              rd_pend_q;
    logic              rd_owner_q;
    logic [DATA_W-1:0] core_rdata_q, dbg_rdata_q;
    logic              lock_now;
    logic              dbg_first;

    // A held lock only applies while dbg_lock stays high; the release cycle arbitrates as ARB_CORE.
    always_comb begin
        lock_now  = (state_q == ARB_LOCK) && dbg_lock;
        dbg_first = lock_now || (state_q == ARB_STARVE);
        dbg_gnt   = !rst_BF && dbg_req && (dbg_first || !core_req);
        core_gnt  = !rst_BF && core_req && !lock_now && !(dbg_req && dbg_first);
    end

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_be    = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (core_gnt) begin
            mem_en    = 1'b1;
            mem_we    = core_we;
            mem_be    = core_be;
            mem_addr  = core_addr;
            mem_wdata = core_wdata;
        end else if (dbg_gnt) begin
            mem_en    = 1'b1;
            mem_we    = dbg_we;
            mem_be    = '1;
            mem_addr  = dbg_addr;
            mem_wdata = dbg_wdata;
        end
    end

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (dbg_gnt) begin
            wait_cnt_d = '0;
        end else if (dbg_req) begin
            if (wait_cnt_q < MAX_W) wait_cnt_d = wait_cnt_q + 8'd1;
        end else if (state_q == ARB_STARVE) begin
            wait_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_BF) begin
            state_q      <= ARB_CORE;
            wait_cnt_q   <= '0;
            rd_pend_q    <= 1'b0;
            rd_owner_q   <= 1'b0;
            core_rdata_q <= '0;
            dbg_rdata_q  <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            rd_pend_q  <= (core_gnt && !core_we) || (dbg_gnt && !dbg_we);
            rd_owner_q <= dbg_gnt;
            if (core_rvalid) core_rdata_q <= mem_rdata;
            if (dbg_rvalid)  dbg_rdata_q  <= mem_rdata;
            case (state_q)
                ARB_CORE, ARB_STARVE: begin
                    if (dbg_gnt && dbg_lock)    state_q <= ARB_LOCK;
                    else if (wait_cnt_d == MAX_W) state_q <= ARB_STARVE;
                    else                        state_q <= ARB_CORE;
                end
                ARB_LOCK: begin
                    if (!dbg_lock) state_q <= (wait_cnt_d == MAX_W) ? ARB_STARVE : ARB_CORE;
                end
                default: state_q <= ARB_CORE;
            endcase
        end
    end

    // Read data passes straight through in the return cycle; the held copy covers idle cycles.
    always_comb begin
        core_rvalid = !rst_BF && rd_pend_q && !rd_owner_q;
        dbg_rvalid  = !rst_BF && rd_pend_q && rd_owner_q;
        core_rdata  = rst_BF ? '0 : (core_rvalid ? mem_rdata : core_rdata_q);
        dbg_rdata   = rst_BF ? '0 : (dbg_rvalid ? mem_rdata : dbg_rdata_q);
        dbg_locked  = !rst_BF && (state_q == ARB_LOCK);
    end

`ifdef DMEM_ARB_PERF_EN
    always_ff @(posedge clk) begin
        if (rst_BF) begin
            perf_conflicts <= '0;
            perf_dbg_stall <= '0;
        end else begin
            if (core_req && dbg_req)  perf_conflicts <= perf_conflicts + 32'd1;
            if (dbg_req && !dbg_gnt)  perf_dbg_stall <= perf_dbg_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter: directed scenarios plus randomized traffic
// checked against a cycle-level reference model with a shadow memory.
module tb_dmem_port_arbiter;
    localparam int ADDR_W   = 10;
    localparam int DATA_W   = 32;
    localparam int MAX_WAIT = 8;

    logic        clk = 1'b0;
    logic        rst_BF = 1'b1;
    logic        core_req = 1'b0, core_we = 1'b0;
    logic [9:0]  core_addr = '0;
    logic [31:0] core_wdata = '0;
    logic [3:0]  core_be = '0;
    logic        dbg_req = 1'b0, dbg_we = 1'b0, dbg_lock = 1'b0;
    logic [9:0]  dbg_addr = '0;
    logic [31:0] dbg_wdata = '0;
    logic        core_gnt, core_rvalid, dbg_gnt, dbg_rvalid, dbg_locked;
    logic [31:0] core_rdata, dbg_rdata;
    logic        mem_en, mem_we;
    logic [3:0]  mem_be;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
`ifdef DMEM_ARB_PERF_EN
    logic [31:0] perf_conflicts, perf_dbg_stall;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dmem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst_BF(rst_BF),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
        .core_wdata(core_wdata), .core_be(core_be), .core_gnt(core_gnt),
        .core_rvalid(core_rvalid), .core_rdata(core_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_lock(dbg_lock),
        .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata), .dbg_gnt(dbg_gnt),
        .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata), .dbg_locked(dbg_locked),
        .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef DMEM_ARB_PERF_EN
        , .perf_conflicts(perf_conflicts), .perf_dbg_stall(perf_dbg_stall)
`endif
    );

    // Data-memory macro: 1-cycle read latency, byte-masked writes.
    logic [31:0] ram [1024];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (mem_be[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            end else begin
                mem_rdata <= ram[mem_addr];
            end
        end
    end

    // Reference model state.
    int          m_wait;
    bit          m_lock, m_pend, m_pend_dbg;
    logic [31:0] m_pend_data, m_core_last, m_dbg_last;
    logic [31:0] ref_mem [1024];
    int unsigned m_conf, m_stall;

    bit          e_cgnt, e_dgnt, e_crv, e_drv, e_locked, e_men, e_mwe;
    logic [3:0]  e_mbe;
    logic [9:0]  e_maddr;
    logic [31:0] e_mwdata, e_crd, e_drd;

    task automatic predict();
        bit lock_now, dbg_first;
        {e_cgnt, e_dgnt, e_crv, e_drv, e_locked, e_men, e_mwe} = '0;
        e_mbe = '0; e_maddr = '0; e_mwdata = '0; e_crd = '0; e_drd = '0;
        if (!rst_BF) begin
            lock_now  = m_lock && dbg_lock;
            dbg_first = lock_now || (m_wait >= MAX_WAIT);
            e_dgnt = dbg_req && (dbg_first || !core_req);
            e_cgnt = core_req && !lock_now && !e_dgnt;
            if (e_cgnt) begin
                e_men = 1; e_mwe = core_we; e_mbe = core_be; e_maddr = core_addr; e_mwdata = core_wdata;
            end else if (e_dgnt) begin
                e_men = 1; e_mwe = dbg_we; e_mbe = 4'hF; e_maddr = dbg_addr; e_mwdata = dbg_wdata;
            end
            e_crv = m_pend && !m_pend_dbg;
            e_drv = m_pend && m_pend_dbg;
            e_crd = e_crv ? m_pend_data : m_core_last;
            e_drd = e_drv ? m_pend_data : m_dbg_last;
            e_locked = m_lock;
        end
    endtask

    task automatic advance();
        @(posedge clk);
        if (rst_BF) begin
            m_wait = 0; m_lock = 0; m_pend = 0; m_pend_dbg = 0;
            m_core_last = '0; m_dbg_last = '0; m_conf = 0; m_stall = 0;
        end else begin
            if (e_crv) m_core_last = m_pend_data;
            if (e_drv) m_dbg_last = m_pend_data;
            if (core_req && dbg_req) m_conf++;
            if (dbg_req && !e_dgnt) m_stall++;
            m_pend      = e_men && !e_mwe;
            m_pend_dbg  = e_dgnt;
            m_pend_data = ref_mem[e_maddr];
            if (e_men && e_mwe)
                for (int b = 0; b < 4; b++)
                    if (e_mbe[b]) ref_mem[e_maddr][8*b +: 8] = e_mwdata[8*b +: 8];
            if (e_dgnt) m_wait = 0;
            else if (dbg_req) m_wait = (m_wait < MAX_WAIT) ? m_wait + 1 : MAX_WAIT;
            else if (m_wait >= MAX_WAIT) m_wait = 0;
            if (e_dgnt && dbg_lock) m_lock = 1;
            else if (m_lock && !dbg_lock) m_lock = 0;
        end
        @(negedge clk);
    endtask

    task automatic idle();
        core_req = 0; core_we = 0; dbg_req = 0; dbg_we = 0; dbg_lock = 0;
    endtask

    task automatic do_reset();
        rst_BF = 1; idle(); predict(); advance(); rst_BF = 0;
    endtask

    task automatic dbg_write(input logic [9:0] a, input logic [31:0] d);
        idle(); dbg_req = 1; dbg_we = 1; dbg_addr = a; dbg_wdata = d;
        predict(); advance(); idle();
    endtask

    task automatic test_reset();
        rst_BF = 1; core_req = 1; dbg_req = 1; dbg_lock = 1;
        core_addr = 10'd3; dbg_addr = 10'd4;
        predict(); #1;
        n_vec++;
        if ({core_gnt, dbg_gnt, core_rvalid, dbg_rvalid, dbg_locked, mem_en, mem_we} !== 7'b0) begin
            n_err++; $display("FAIL reset_flags: got %b want 0", {core_gnt, dbg_gnt, core_rvalid, dbg_rvalid, dbg_locked, mem_en, mem_we});
        end
        n_vec++;
        if ({mem_be, mem_addr, mem_wdata, core_rdata, dbg_rdata} !== '0) begin
            n_err++; $display("FAIL reset_data: got %h want 0", {mem_be, mem_addr, mem_wdata, core_rdata, dbg_rdata});
        end
        advance(); rst_BF = 0; idle();
    endtask

    task automatic test_preload_core_read();
        idle(); dbg_req = 1; dbg_we = 1; dbg_addr = 10'd378; dbg_wdata = 32'h8;
        predict(); #1;
        n_vec++;
        if ({dbg_gnt, mem_en, mem_we, mem_be, mem_addr} !== {3'b111, 4'hF, 10'd378}) begin
            n_err++; $display("FAIL preload_dbg_write: got %h", {dbg_gnt, mem_en, mem_we, mem_be, mem_addr});
        end
        advance(); idle();
        core_req = 1; core_we = 0; core_addr = 10'd378; core_be = 4'hF;
        predict(); #1;
        n_vec++;
        if (core_gnt !== 1'b1) begin n_err++; $display("FAIL core_read_gnt: got %b want 1", core_gnt); end
        advance(); idle();
        predict(); #1;
        n_vec++;
        if ({core_rvalid, dbg_rvalid, core_rdata} !== {2'b10, 32'h0000_0008}) begin
            n_err++; $display("FAIL core_read_return: got rv=%b%b data=%h want rv=10 data=00000008", core_rvalid, dbg_rvalid, core_rdata);
        end
        advance();
    endtask

    task automatic test_starvation();
        bit got = 0;
        int unsigned gcycle = 0, ccnt = 0;
        logic [31:0] v = 32'h5A00_0000 | 32'($urandom_range(1, 65535));
        do_reset();
        dbg_write(10'd369, v);
        core_req = 1; core_we = 0; core_be = 4'hF;
        dbg_req = 1; dbg_we = 0; dbg_addr = 10'd369;
        for (int unsigned n = 1; n <= 20 && !got; n++) begin
            core_addr = 10'($urandom_range(0, 1023));
            predict(); #1;
            if (dbg_gnt) begin
                got = 1; gcycle = n;
                n_vec++;
                if (core_gnt !== 1'b0) begin n_err++; $display("FAIL starve_core_blocked: got %b want 0", core_gnt); end
            end else if (core_gnt) ccnt++;
            advance();
        end
        n_vec++;
        if (gcycle !== MAX_WAIT + 1 || ccnt !== MAX_WAIT) begin
            n_err++; $display("FAIL starve_grant_cycle: got dbg cycle %0d core grants %0d want %0d/%0d", gcycle, ccnt, MAX_WAIT + 1, MAX_WAIT);
        end
        dbg_req = 0;
        predict(); #1;
        n_vec++;
        if ({dbg_rvalid, dbg_rdata, core_gnt} !== {1'b1, v, 1'b1}) begin
            n_err++; $display("FAIL starve_return: got rv=%b data=%h cgnt=%b want 1/%h/1", dbg_rvalid, dbg_rdata, core_gnt, v);
        end
`ifdef DMEM_ARB_PERF_EN
        n_vec++;
        if (perf_dbg_stall !== 32'd8 || perf_conflicts !== 32'd9) begin
            n_err++; $display("FAIL starve_perf: got stall=%0d conf=%0d want 8/9", perf_dbg_stall, perf_conflicts);
        end
`endif
        advance(); idle();
    endtask

    task automatic test_lock();
        int unsigned idx = 0, rv = 0;
        do_reset();
        for (int unsigned i = 368; i <= 378; i++) dbg_write(10'(i), $urandom);
        core_req = 1; core_we = 0; core_addr = 10'd7; core_be = 4'hF;
        dbg_req = 1; dbg_we = 0; dbg_lock = 1;
        for (int unsigned n = 0; n < 60 && idx < 11; n++) begin
            dbg_addr = 10'(368 + idx);
            predict(); #1;
            if (dbg_rvalid) begin
                rv++; n_vec++;
                if (dbg_rdata !== e_drd) begin n_err++; $display("FAIL lock_rdata: got %h want %h", dbg_rdata, e_drd); end
            end
            if (idx > 0) begin
                n_vec++;
                if (core_gnt !== 1'b0 || dbg_locked !== 1'b1) begin
                    n_err++; $display("FAIL lock_hold: got cgnt=%b locked=%b want 0/1", core_gnt, dbg_locked);
                end
            end
            if (dbg_gnt) begin
                if (idx == 0) begin
                    n_vec++;
                    if (dbg_locked !== 1'b0) begin n_err++; $display("FAIL lock_first: got locked=%b want 0", dbg_locked); end
                end
                idx++;
            end
            advance();
        end
        n_vec++;
        if (idx !== 11) begin n_err++; $display("FAIL lock_grants: got %0d want 11", idx); end
        dbg_req = 0;
        predict(); #1;
        if (dbg_rvalid) begin
            rv++; n_vec++;
            if (dbg_rdata !== e_drd) begin n_err++; $display("FAIL lock_rdata_last: got %h want %h", dbg_rdata, e_drd); end
        end
        n_vec++;
        if (core_gnt !== 1'b0 || dbg_locked !== 1'b1) begin n_err++; $display("FAIL lock_idle: got cgnt=%b locked=%b want 0/1", core_gnt, dbg_locked); end
        advance();
        n_vec++;
        if (rv !== 11) begin n_err++; $display("FAIL lock_rvalid_count: got %0d want 11", rv); end
        dbg_lock = 0;
        predict(); #1;
        n_vec++;
        if (core_gnt !== 1'b1) begin n_err++; $display("FAIL lock_release: got cgnt=%b want 1", core_gnt); end
        advance(); idle();
    endtask

    task automatic test_alternate();
        logic [31:0] v5 = $urandom, v6 = ~v5;
        bit prev_dbg = 0;
        dbg_write(10'd5, v5); dbg_write(10'd6, v6);
        for (int unsigned k = 0; k <= 8; k++) begin
            idle();
            if (k < 8) begin
                if (k % 2 == 0) begin core_req = 1; core_addr = 10'd5; core_be = 4'hF; end
                else begin dbg_req = 1; dbg_addr = 10'd6; end
            end
            predict(); #1;
            if (k > 0) begin
                n_vec++;
                if ({core_rvalid, dbg_rvalid, prev_dbg ? dbg_rdata : core_rdata} !== {!prev_dbg, prev_dbg, prev_dbg ? v6 : v5}) begin
                    n_err++; $display("FAIL alternate_k%0d: got rv=%b%b c=%h d=%h want owner dbg=%b", k, core_rvalid, dbg_rvalid, core_rdata, dbg_rdata, prev_dbg);
                end
            end
            prev_dbg = (k % 2 == 1);
            advance();
        end
        idle();
    endtask

    task automatic test_byte_enable();
        dbg_write(10'd100, 32'h1122_3344);
        core_req = 1; core_we = 1; core_addr = 10'd100; core_be = 4'b0010; core_wdata = 32'hAABB_CCDD;
        predict(); #1;
        n_vec++;
        if ({core_gnt, mem_en, mem_we, mem_be, mem_wdata} !== {3'b111, 4'b0010, 32'hAABB_CCDD}) begin
            n_err++; $display("FAIL be_write: got %h", {core_gnt, mem_en, mem_we, mem_be, mem_wdata});
        end
        advance(); idle();
        dbg_req = 1; dbg_addr = 10'd100;
        predict(); #1;
        n_vec++;
        if ({core_rvalid, dbg_rvalid} !== 2'b00) begin n_err++; $display("FAIL be_no_rvalid: got %b%b want 00", core_rvalid, dbg_rvalid); end
        advance(); idle();
        predict(); #1;
        n_vec++;
        if ({dbg_rvalid, dbg_rdata} !== {1'b1, 32'h1122_CC44}) begin
            n_err++; $display("FAIL be_readback: got rv=%b data=%h want 1/1122cc44", dbg_rvalid, dbg_rdata);
        end
        advance();
    endtask

    task automatic test_reset_mid();
        bit got = 0;
        int unsigned gcycle = 0;
        idle();
        core_req = 1; core_we = 0; core_addr = 10'd20; core_be = 4'hF;
        dbg_req = 1; dbg_we = 0; dbg_addr = 10'd21;
        for (int unsigned i = 0; i < 4; i++) begin predict(); advance(); end
        rst_BF = 1;
        predict(); #1;
        n_vec++;
        if ({core_gnt, dbg_gnt, core_rvalid, dbg_rvalid, dbg_locked, mem_en, mem_we, mem_be, mem_addr, mem_wdata, core_rdata, dbg_rdata} !== '0) begin
            n_err++; $display("FAIL reset_mid: got rv=%b%b gnt=%b%b en=%b", core_rvalid, dbg_rvalid, core_gnt, dbg_gnt, mem_en);
        end
        advance(); rst_BF = 0;
        for (int unsigned n = 1; n <= 20 && !got; n++) begin
            predict(); #1;
            if (n == 1) begin
                n_vec++;
                if ({core_gnt, dbg_gnt, core_rvalid, core_rdata} !== {3'b100, 32'h0}) begin
                    n_err++; $display("FAIL reset_mid_after: got cgnt=%b dgnt=%b rv=%b rd=%h want 1/0/0/0", core_gnt, dbg_gnt, core_rvalid, core_rdata);
                end
            end
            if (dbg_gnt) begin got = 1; gcycle = n; end
            advance();
        end
        n_vec++;
        if (gcycle !== MAX_WAIT + 1) begin n_err++; $display("FAIL reset_mid_wait: got dbg cycle %0d want %0d", gcycle, MAX_WAIT + 1); end
        idle(); predict(); advance();
    endtask

    task automatic test_random();
        logic [116:0] obs, exp;
        do_reset();
        for (int unsigned c = 0; c < 600; c++) begin
            if (!core_req) begin
                core_req = ($urandom_range(0, 3) != 0); core_we = $urandom_range(0, 1);
                core_addr = 10'(360 + $urandom_range(0, 23)); core_wdata = $urandom; core_be = 4'($urandom);
            end
            if (!dbg_req) begin
                dbg_req = $urandom_range(0, 1); dbg_we = $urandom_range(0, 1);
                dbg_addr = 10'(360 + $urandom_range(0, 23)); dbg_wdata = $urandom;
            end
            if ($urandom_range(0, 7) == 0) dbg_lock = ~dbg_lock;
            rst_BF = ($urandom_range(0, 63) == 0);
            predict(); #1;
            obs = {core_gnt, dbg_gnt, core_rvalid, dbg_rvalid, dbg_locked, mem_en, mem_we, mem_be, mem_addr, mem_wdata, core_rdata, dbg_rdata};
            exp = {e_cgnt, e_dgnt, e_crv, e_drv, e_locked, e_men, e_mwe, e_mbe, e_maddr, e_mwdata, e_crd, e_drd};
            n_vec++;
            if (obs !== exp) begin n_err++; $display("FAIL random_c%0d: got %h want %h", c, obs, exp); end
`ifdef DMEM_ARB_PERF_EN
            n_vec++;
            if (perf_conflicts !== m_conf || perf_dbg_stall !== m_stall) begin
                n_err++; $display("FAIL random_perf_c%0d: got %0d/%0d want %0d/%0d", c, perf_conflicts, perf_dbg_stall, m_conf, m_stall);
            end
`endif
            advance();
            if (e_cgnt) core_req = 0;
            if (e_dgnt) dbg_req = 0;
        end
        rst_BF = 0; idle();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int unsigned i = 0; i < 1024; i++) begin ram[i] = '0; ref_mem[i] = '0; end
        @(negedge clk);
        test_reset();
        test_preload_core_read();
        test_starvation();
        test_lock();
        test_alternate();
        test_byte_enable();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/dmem_port_arbiter.md
# dmem_port_arbiter

Shares the single-port synchronous data memory between the core's memory stage and a debug/test-access port, which is used for memory preload and result dumps such as sorted-array checks. Fixed core priority, a starvation guard for the debug port, and a debug lock mode that stalls the core for exclusive dump access. Sits between CPU memory stage, debug port and the data-memory macro; routes 1-cycle read data back to the owning requester.

## Interface
- ADDR_W, 10, word-address width (1024 words)
- DATA_W, 32, data width; byte enables are DATA_W/8 bits
- MAX_WAIT, 8, debug wait cycles before forced priority (1..255)
- clk  in  1  clock
- rst_BF  in  1  synchronous, active-high reset
- core_req / core_we  in  1 / 1  core access request / write
- core_addr / core_wdata / core_be  in  ADDR_W / DATA_W / DATA_W/8  core address, write data, byte enables
- core_gnt  out  1  core access accepted this cycle (combinational)
- core_rvalid / core_rdata  out  1 / DATA_W  core read return
- dbg_req / dbg_we / dbg_lock  in  1 / 1 / 1  debug request / write / exclusive-lock request
- dbg_addr / dbg_wdata  in  ADDR_W / DATA_W  debug address / write data (full-word writes)
- dbg_gnt  out  1  debug access accepted (combinational)
- dbg_rvalid / dbg_rdata  out  1 / DATA_W  debug read return
- dbg_locked  out  1  lock held; core is blocked
- mem_en / mem_we / mem_be  out  1 / 1 / DATA_W/8  memory strobe, write, byte enables
- mem_addr / mem_wdata  out  ADDR_W / DATA_W  memory address / write data
- mem_rdata  in  DATA_W  memory read data, valid 1 cycle after a read strobe

## Operation
- FSM states: ARB_CORE (reset), ARB_STARVE, ARB_LOCK.
- ARB_CORE: core_req wins. dbg_gnt only when core_req=0.
- wait_cnt (8 bit): +1 each cycle dbg_req=1 and dbg_gnt=0; cleared on dbg_gnt. Saturates at MAX_WAIT.
- ARB_CORE -> ARB_STARVE when wait_cnt reaches MAX_WAIT. In ARB_STARVE, debug wins any conflict. After exactly one debug grant -> ARB_CORE. If dbg_req drops before a grant -> ARB_CORE, and wait_cnt clears.
- ARB_CORE or ARB_STARVE -> ARB_LOCK when dbg_lock=1 in the same cycle as a debug grant. In ARB_LOCK: core_gnt=0, debug always granted, dbg_locked=1. ARB_LOCK -> ARB_CORE on the first cycle dbg_lock=0. That cycle arbitrates as ARB_CORE.
- A granted request drives mem_en=1 with the winner's fields; mem_we copies the winner's we. Debug mem_be is all ones.
- Nothing granted: mem_en=0, mem_we=0, and other mem_* outputs are 0.
- Read return: registers rd_owner and rd_pend on the grant of a read. In the next cycle, the owner's rvalid=1 and its rdata=mem_rdata. A write produces no rvalid. Back-to-back reads from alternating owners are supported at one per cycle.
- rdata of the non-owner holds its last returned value.
- Requests are level-held. A requester keeps req and fields stable until it sees gnt.

## Timing
- Grant: 0 cycles (combinational from req, FSM state and wait_cnt). Read data: 1 cycle after grant.
- Throughput: 1 access/cycle total.
- Reset values: core_gnt=dbg_gnt=0 during reset, core_rvalid=dbg_rvalid=0, rdata=0, dbg_locked=0, all mem_*=0, FSM=ARB_CORE, wait_cnt=0.
- Reset mid-operation: a read granted in the cycle before reset returns no rvalid. Reset is sampled at the same edge and clears rd_pend.
- Simultaneous requests, ARB_CORE, wait_cnt<MAX_WAIT: core. ARB_STARVE: debug. ARB_LOCK: debug only.
- dbg_lock asserted without dbg_req has no effect.

## Configuration
- DMEM_ARB_PERF_EN defined: adds outputs perf_conflicts (32 bit) and perf_dbg_stall (32 bit).
  - perf_conflicts: +1 each cycle both requests are present.
  - perf_dbg_stall: +1 each cycle dbg_req=1 and dbg_gnt=0.
  - Both wrap at 2^32, clear on rst_BF, and are readable at any time.
- DMEM_ARB_PERF_EN undefined: the ports and counters do not exist. Arbitration behaviour is identical.

## Test plan
- Core-only read of addr 378 after preload 0x8 via debug write -> core_gnt same cycle, core_rvalid next cycle, core_rdata=0x00000008, dbg_rvalid=0.
- Continuous core_req plus dbg_req read of addr 369, MAX_WAIT=8 -> core granted 8 cycles, debug granted on the 9th cycle, dbg_rdata valid the cycle after, then core priority resumes. With PERF: perf_dbg_stall=8.
- dbg_lock=1 with reads of 368..378 while core_req=1 -> dbg_locked=1 from the cycle after the first grant, 11 consecutive dbg_rvalid pulses, core_gnt=0 throughout, core granted the cycle dbg_lock drops.
- Alternating core read (addr 5) / debug read (addr 6) on consecutive cycles -> rvalid alternates each cycle to the correct owner with no data swap.
- Core write, core_be=4'b0010, data 0xAABBCCDD -> mem_be=4'b0010, mem_we=1, no rvalid. A following debug read of the same address returns only byte 1 updated.
- rst_BF asserted the cycle after a granted read -> no rvalid, all outputs at reset values, FSM in ARB_CORE, wait_cnt=0.
